// File: rtl/shot_clock_pkg.sv
// Shared types and segment patterns for the shot-clock display slice.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package shot_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLASH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/shot_clock_display_decode.sv
// Combinational BCD to active-high seven-segment pattern.
// Codes above 9 show a dash so a corrupted timer digit is visible.
module seven_seg_decode
  import shot_clock_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (digit)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/shot_clock_display.sv
// Two-digit multiplexed display for the shot-clock countdown: leading-zero
// blanking while running, flashing "00" with buzzer on expiry, then a steady hold.
module shot_clock_display
  import shot_clock_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int FLASH_DIV    = 25000000,
  parameter int FLASH_CYCLES = 6,
  parameter bit SEG_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] msb,
  input  logic [3:0] lsb,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       expired,
  output logic       buzzer
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int PW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST   = FW'(FLASH_DIV - 1);
  localparam logic [PW-1:0] FLIP_LAST    = PW'(FLASH_CYCLES - 1);
  localparam logic [6:0]    SEG_OFF      = SEG_ACT_LOW ? 7'h7F : 7'h00;

  state_t          state;
  logic [3:0]      msb_q, lsb_q;
  logic            zero_prev;
  logic [RW-1:0]   refresh_cnt;
  logic [FW-1:0]   flash_cnt;
  logic [PW-1:0]   flip_cnt;
  logic            flash_on;
  logic            cnt_zero;
  logic [1:0]      an_next;
  logic [3:0]      digit_sel;
  logic [6:0]      digit_pat;
  logic [6:0]      seg_hi;

  assign cnt_zero  = (msb_q == 4'd0) && (lsb_q == 4'd0);
  assign an_next   = (refresh_cnt == REFRESH_LAST) ? {an[0], an[1]} : an;
  assign digit_sel = an_next[1] ? msb_q : lsb_q;
  assign expired   = (state == ST_FLASH) || (state == ST_HOLD);
  assign buzzer    = (state == ST_FLASH) && flash_on;

  seven_seg_decode u_decode (
    .digit   (digit_sel),
    .pattern (digit_pat)
  );

  // The pattern is chosen for the slot that becomes active at this edge, so seg and an stay aligned.
  always_comb begin
    seg_hi = SEG_BLANK;
    case (state)
      ST_FLASH: seg_hi = flash_on ? SEG_0 : SEG_BLANK;
      ST_HOLD:  seg_hi = SEG_0;
      default:  seg_hi = (an_next[1] && (msb_q == 4'd0)) ? SEG_BLANK : digit_pat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      msb_q       <= 4'd0;
      lsb_q       <= 4'd0;
      zero_prev   <= 1'b0;
      refresh_cnt <= '0;
      an          <= 2'b01;
      seg         <= SEG_OFF;
    end else begin
      msb_q       <= msb;
      lsb_q       <= lsb;
      zero_prev   <= cnt_zero;
      refresh_cnt <= (refresh_cnt == REFRESH_LAST) ? '0 : refresh_cnt + 1'b1;
      an          <= an_next;
      seg         <= SEG_ACT_LOW ? ~seg_hi : seg_hi;
    end
  end

  // A reload wins over everything; expiry fires only on the edge where the count first reads 00.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      flash_cnt <= '0;
      flip_cnt  <= '0;
      flash_on  <= 1'b0;
    end else if (load) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_IDLE: if (!cnt_zero) state <= ST_RUN;
        ST_RUN: begin
          if (cnt_zero && !zero_prev) begin
            state     <= ST_FLASH;
            flash_cnt <= '0;
            flip_cnt  <= '0;
            flash_on  <= 1'b1;
          end
        end
        ST_FLASH: begin
          if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            flash_on  <= ~flash_on;
            if (flip_cnt == FLIP_LAST) begin
              state    <= ST_HOLD;
              flip_cnt <= '0;
            end else begin
              flip_cnt <= flip_cnt + 1'b1;
            end
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
          end
        end
        ST_HOLD: state <= ST_HOLD;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_clock_display.sv
// Bench for shot_clock_display: directed scenarios with literal expectations,
// then randomized digits/loads/resets checked every cycle against a time-based model.
module tb_shot_clock_display;

  localparam int RD = 4;
  localparam int FD = 8;
  localparam int FC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] msb = 4'd0;
  logic [3:0] lsb = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       expired;
  logic       buzzer;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] digit_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // model state: edges since reset, captured digits, mode (0 idle, 1 run, 2 expired), time since expiry
  int         n;
  int         mode;
  int         t;
  logic [3:0] cap_m, cap_l;
  logic       zero_prev;
  logic [1:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_expired, exp_buzzer;
  bit         model_valid = 1'b0;

  shot_clock_display #(
    .REFRESH_DIV  (RD),
    .FLASH_DIV    (FD),
    .FLASH_CYCLES (FC),
    .SEG_ACT_LOW  (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .msb     (msb),
    .lsb     (lsb),
    .load    (load),
    .seg     (seg),
    .an      (an),
    .expired (expired),
    .buzzer  (buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    if (d > 4'd9) return 7'h40;
    return digit_tbl[d];
  endfunction

  task automatic check_output(input string name, input logic [6:0] actual, input logic [6:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic wait_slot(input logic [1:0] target);
    int k = 0;
    while (an !== target && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (an !== target) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL slot_wait: an=%b, expected %b", an, target);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] m, input logic [3:0] l, input int cycles);
    msb = m;
    lsb = l;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: scan slot from elapsed cycles, flash phase from time since expiry.
  initial begin : model
    logic       tens, zero_now, on, flashing;
    logic [6:0] hi;
    forever begin
      @(posedge clk);
      if (!rst) begin
        n = 0; mode = 0; t = 0;
        cap_m = 4'd0; cap_l = 4'd0; zero_prev = 1'b0;
        exp_an = 2'b01; exp_seg = 7'h7F;
      end else begin
        n++;
        tens = ((n / RD) % 2) == 1;
        flashing = (mode == 2) && (t < FD * FC);
        on = ((t / FD) % 2) == 0;
        if (mode == 2) hi = (flashing && !on) ? 7'h00 : 7'h3F;
        else if (tens) hi = (cap_m == 4'd0) ? 7'h00 : pattern(cap_m);
        else hi = pattern(cap_l);
        exp_seg = ~hi;
        exp_an = tens ? 2'b10 : 2'b01;
        zero_now = (cap_m == 4'd0) && (cap_l == 4'd0);
        if (load) mode = 1;
        else if (mode == 0 && !zero_now) mode = 1;
        else if (mode == 1 && zero_now && !zero_prev) begin mode = 2; t = 0; end
        else if (mode == 2 && t < FD * FC) t++;
        zero_prev = zero_now;
        cap_m = msb;
        cap_l = lsb;
      end
      exp_expired = (mode == 2);
      exp_buzzer = (mode == 2) && (t < FD * FC) && (((t / FD) % 2) == 0);
      model_valid = 1'b1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check_output("model_an", {5'd0, an}, {5'd0, exp_an});
        check_output("model_seg", seg, exp_seg);
        check_output("model_expired", {6'd0, expired}, {6'd0, exp_expired});
        check_output("model_buzzer", {6'd0, buzzer}, {6'd0, exp_buzzer});
      end
    end
  end

  initial begin : stimulus
    int hold_left = 0;
    repeat (3) @(negedge clk);
    check_output("reset_an", {5'd0, an}, 7'd1);
    check_output("reset_seg", seg, 7'h7F);
    check_output("reset_expired", {6'd0, expired}, 7'd0);
    check_output("reset_buzzer", {6'd0, buzzer}, 7'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("scan_before_toggle", {5'd0, an}, 7'd1);
    @(negedge clk);
    check_output("scan_first_toggle", {5'd0, an}, 7'd2);

    apply_stimulus(4'd2, 4'd4, 3);
    wait_slot(2'b01);
    check_output("units_4", seg, 7'h19);
    wait_slot(2'b10);
    check_output("tens_2", seg, 7'h24);

    apply_stimulus(4'd0, 4'd7, 3);
    wait_slot(2'b10);
    check_output("tens_blank", seg, 7'h7F);
    wait_slot(2'b01);
    check_output("units_7", seg, 7'h78);

    apply_stimulus(4'd0, 4'd1, 3);
    apply_stimulus(4'd0, 4'd0, 1);
    check_output("expiry_latency_1", {6'd0, expired}, 7'd0);
    @(negedge clk);
    check_output("expiry_latency_2", {6'd0, expired}, 7'd1);
    check_output("flash_first_on", {6'd0, buzzer}, 7'd1);
    repeat (8) @(negedge clk);
    check_output("flash_first_off", {6'd0, buzzer}, 7'd0);
    repeat (24) @(negedge clk);
    check_output("hold_expired", {6'd0, expired}, 7'd1);
    check_output("hold_buzzer", {6'd0, buzzer}, 7'd0);
    wait_slot(2'b01);
    check_output("hold_units", seg, 7'h40);
    wait_slot(2'b10);
    check_output("hold_tens", seg, 7'h40);

    load = 1'b1;
    apply_stimulus(4'd0, 4'd1, 1);
    load = 1'b0;
    check_output("load_clears_hold", {6'd0, expired}, 7'd0);
    apply_stimulus(4'd0, 4'd1, 3);
    apply_stimulus(4'd0, 4'd0, 2);
    repeat (23) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_output("load_prio_expired", {6'd0, expired}, 7'd0);
    check_output("load_prio_buzzer", {6'd0, buzzer}, 7'd0);

    apply_stimulus(4'd3, 4'hC, 3);
    wait_slot(2'b01);
    check_output("bad_bcd_dash", seg, 7'h3F);
    check_output("bad_bcd_no_expiry", {6'd0, expired}, 7'd0);

    apply_stimulus(4'd0, 4'd1, 3);
    apply_stimulus(4'd0, 4'd0, 4);
    check_output("preflash_buzzer", {6'd0, buzzer}, 7'd1);
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_flash_buzzer", {6'd0, buzzer}, 7'd0);
    check_output("rst_flash_expired", {6'd0, expired}, 7'd0);
    check_output("rst_flash_an", {5'd0, an}, 7'd1);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_output("idle_after_rst", {6'd0, expired}, 7'd0);

    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 7))
          0, 1:    begin msb = 4'd0; lsb = 4'd0; end
          2, 3:    begin msb = 4'd0; lsb = 4'($urandom_range(1, 9)); end
          4:       begin msb = 4'($urandom_range(0, 15)); lsb = 4'($urandom_range(0, 15)); end
          default: begin msb = 4'($urandom_range(0, 9)); lsb = 4'($urandom_range(0, 9)); end
        endcase
        hold_left = $urandom_range(1, 40);
      end else begin
        hold_left--;
      end
      load = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    load = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
